spi_boot_loader: RTL and testbench
==================================

Name: spi_boot_loader

Overview:
- TL-UL host sequencer sitting directly upstream of the SPI host peripheral. It drives the peripheral's register port to read a program image from serial flash, using READ command 0x03 with a 24-bit address.
- Each received 32-bit word is emitted on a write port into instruction memory.
- Runs once per start pulse and holds the core in boot until done or error.

Parameters:
- SPI_BASE, 32'h4008_0000, TL-UL base address of SPI host registers
- CLK_DIV, 16'd1, value written to DIVIDER register
- SS_MASK, 8'h01, value written to SS register
- MEM_AW, 14, word-address width of memory write port

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  single-cycle pulse; begins boot when idle
- flash_base_i  in  24  flash byte address of first word; sampled at start
- word_count_i  in  16  words to load; sampled at start; 0 means done immediately
- tl_o  out  tlul_pkg::tl_h2d_t  TL-UL A channel to SPI host
- tl_i  in  tlul_pkg::tl_d2h_t  TL-UL D channel from SPI host
- mem_we_o  out  1  memory write strobe, one cycle per word
- mem_addr_o  out  MEM_AW  word address, 0-based from start
- mem_wdata_o  out  32  word data
- busy_o  out  1  high from start accepted until DONE/ERR
- done_o  out  1  sticky; set on completion
- err_o  out  1  sticky; set on TL-UL error response

Behaviour:
- Reset values: all outputs 0; tl_o.a_valid=0; tl_o.d_ready=1 always; state IDLE.
- Register offsets (package constants): RX0/TX0 0x00, TX1 0x04, CTRL 0x10, DIVIDER 0x14, SS 0x18.
- CTRL bits: CHAR_LEN[6:0], GO_BSY[8], Tx_NEG[10], ASS[13].
- CTRL_GO value is 32'h0000_2540: CHAR_LEN=64, Tx_NEG, ASS, GO.
- Bus access rules:
  - Exactly one outstanding transaction.
  - Hold a_valid with stable fields until a_ready sampled high.
  - Then wait for d_valid before the next access.
  - Writes use PutFullData, a_mask=4'hF, a_size=2, a_source=0.
  - Reads use Get.
  - d_error=1 on any response -> ERR.
- FSM (each bus state issues its access and advances on d_valid):
  - IDLE --start_i--> WR_DIV, or DONE if word_count_i==0.
  - WR_DIV --> WR_SS.
  - WR_SS --> WR_TX1. TX1 data = {8'h03, cur_addr}.
  - WR_TX1 --> WR_TX0. TX0 data = 0.
  - WR_TX0 --> WR_CTRL. CTRL data = CTRL_GO.
  - WR_CTRL --> POLL.
  - POLL reads CTRL. d_data[8]=1 -> reissue POLL; 0 -> RD_RX.
  - RD_RX reads RX0 -> EMIT.
  - EMIT, one cycle:
    - mem_we_o=1, mem_addr_o=word_idx, mem_wdata_o=captured RX0.
    - Then word_idx+=1 and cur_addr+=4.
    - If word_idx+1==count -> DONE; else -> WR_TX1.
  - DONE: done_o=1, busy_o=0, stays until reset.
  - ERR: err_o=1, busy_o=0, stays until reset.
- start_i is ignored outside IDLE.
- cur_addr wraps modulo 2^24.
- mem_addr_o is truncated to MEM_AW; count beyond 2^MEM_AW wraps the memory address without error.
- Reset mid-transaction: state drops to IDLE immediately and a_valid deasserts; any in-flight response is dropped via d_ready=1 in IDLE.
- A response arriving in IDLE is discarded.

Optional Feature:
- SPI_BOOT_BYTESWAP_EN defined: mem_wdata_o = byte-reversed RX0, for flash images stored little-endian.
- Undefined: mem_wdata_o = RX0 unchanged.

Decomposition:
- spi_boot_pkg: state enum, register offsets, CTRL_GO, READ opcode.
- One sub-module, spi_boot_tl_req, owns the single-outstanding TL-UL handshake:
  - Inputs: req, we, addr, wdata.
  - Outputs: rsp_valid, rsp_data, rsp_err.
- The top FSM only sequences.

Test Plan:
- flash_base=0x000100, count=2; model returns RX0 0xDEADBEEF, 0x01234567. Expect writes 0x14=1, 0x18=1, 0x04=0x03000100, 0x00=0, 0x10=0x2540, ...; mem writes (0,0xDEADBEEF), (1,0x01234567); done_o=1.
- Poll stall: GO_BSY reads 1 three times then 0 -> exactly 4 CTRL reads, then one RX0 read; data correct.
- a_ready held low 5 cycles on WR_TX1 -> a_valid/address/data stable throughout; no duplicate transaction.
- d_error=1 on POLL response -> err_o=1, busy_o=0, no further a_valid, no mem_we_o.
- count=0 -> no TL-UL traffic; done_o=1 the cycle after start. flash_base=0xFFFFFC, count=2 -> second TX1=0x03000000.
- rst_i asserted during POLL -> all outputs 0 next cycle. A subsequent start replays the sequence from WR_DIV. With SPI_BOOT_BYTESWAP_EN, 0xDEADBEEF is written as 0xEFBEADDE.

Source files
------------

// File: rtl/spi_boot_pkg.sv
// Boot loader states, SPI host register map and the command constants used to
// fetch one 32-bit word per SPI transfer.
package spi_boot_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_DIV,
    ST_WR_SS,
    ST_WR_TX1,
    ST_WR_TX0,
    ST_WR_CTRL,
    ST_POLL,
    ST_RD_RX,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  localparam logic [31:0] REG_RX0     = 32'h00;
  localparam logic [31:0] REG_TX0     = 32'h00;
  localparam logic [31:0] REG_TX1     = 32'h04;
  localparam logic [31:0] REG_CTRL    = 32'h10;
  localparam logic [31:0] REG_DIVIDER = 32'h14;
  localparam logic [31:0] REG_SS      = 32'h18;

  // CHAR_LEN=64, Tx_NEG, ASS, GO_BSY
  localparam logic [31:0] CTRL_GO         = 32'h0000_2540;
  localparam int          CTRL_GO_BSY_BIT = 8;
  localparam logic [7:0]  FLASH_READ_OP   = 8'h03;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types (A: host->device, D: device->host) shared by the
// boot loader and its bench.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/spi_boot_loader_if.sv
// TL-UL link between the boot sequencer's request engine and the SPI host.
interface spi_boot_loader_if;
  tlul_pkg::tl_h2d_t h2d;
  tlul_pkg::tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/spi_boot_tl_req.sv
// Single-outstanding TL-UL request engine: latches one access, holds A until
// a_ready, then waits for the D response before accepting another request.
module spi_boot_tl_req (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_data_o,
  output logic                      rsp_err_o,
  spi_boot_loader_if.master         tl
);

  logic        a_pend_q, a_pend_d;
  logic        d_wait_q, d_wait_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        idle;

  assign idle = !a_pend_q && !d_wait_q;

  always_comb begin
    a_pend_d = a_pend_q;
    d_wait_d = d_wait_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (idle && req_i) begin
      a_pend_d = 1'b1;
      we_d     = we_i;
      addr_d   = addr_i;
      wdata_d  = we_i ? wdata_i : 32'h0;
    end
    if (a_pend_q && tl.d2h.a_ready) begin
      a_pend_d = 1'b0;
      d_wait_d = 1'b1;
    end
    if (d_wait_q && tl.d2h.d_valid) begin
      d_wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_pend_q <= 1'b0;
      d_wait_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      a_pend_q <= a_pend_d;
      d_wait_q <= d_wait_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Responses outside a pending access (e.g. after reset) are swallowed here.
  assign rsp_valid_o = d_wait_q && tl.d2h.d_valid;
  assign rsp_data_o  = tl.d2h.d_data;
  assign rsp_err_o   = tl.d2h.d_error;

  always_comb begin
    tl.h2d           = '0;
    tl.h2d.a_valid   = a_pend_q;
    tl.h2d.a_opcode  = we_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
    tl.h2d.a_param   = 3'h0;
    tl.h2d.a_size    = 2'd2;
    tl.h2d.a_source  = 8'h0;
    tl.h2d.a_address = addr_q;
    tl.h2d.a_mask    = 4'hF;
    tl.h2d.a_data    = wdata_q;
    tl.h2d.d_ready   = 1'b1;
  end

  logic unused_d2h;
  assign unused_d2h = ^{tl.d2h.d_opcode, tl.d2h.d_param, tl.d2h.d_size,
                        tl.d2h.d_source, tl.d2h.d_sink};

endmodule

// File: rtl/spi_boot_loader.sv
// SPI flash boot sequencer: reads word_count words via the SPI host and writes
// them to instruction memory. Define SPI_BOOT_BYTESWAP_EN for little-endian images.
module spi_boot_loader
  import spi_boot_pkg::*;
#(
  parameter logic [31:0] SPI_BASE = 32'h4008_0000,
  parameter logic [15:0] CLK_DIV  = 16'd1,
  parameter logic [7:0]  SS_MASK  = 8'h01,
  parameter int          MEM_AW   = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [23:0]       flash_base_i,
  input  logic [15:0]       word_count_i,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  function automatic logic [31:0] fmt_word(input logic [31:0] w);
`ifdef SPI_BOOT_BYTESWAP_EN
    fmt_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    fmt_word = w;
`endif
  endfunction

  spi_boot_loader_if tl_bus ();

  assign tl_o       = tl_bus.h2d;
  assign tl_bus.d2h = tl_i;

  logic        req, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  spi_boot_tl_req u_tl_req (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req),
    .we_i        (req_we),
    .addr_i      (req_addr),
    .wdata_i     (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .tl          (tl_bus.master)
  );

  boot_state_e       state_q, state_d, bus_next;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [15:0]       count_q, count_d;
  logic [23:0]       cur_addr_q, cur_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    count_d     = count_q;
    cur_addr_d  = cur_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    req         = 1'b0;
    req_we      = 1'b0;
    req_addr    = SPI_BASE;
    req_wdata   = 32'h0;
    bus_next    = state_q;

    // Each bus state names its access and the state that follows its response.
    case (state_q)
      ST_WR_DIV:  begin req = 1'b1; req_we = 1'b1; req_addr = SPI_BASE + REG_DIVIDER;
                        req_wdata = {16'h0, CLK_DIV}; bus_next = ST_WR_SS; end
      ST_WR_SS:   begin req = 1'b1; req_we = 1'b1; req_addr = SPI_BASE + REG_SS;
                        req_wdata = {24'h0, SS_MASK}; bus_next = ST_WR_TX1; end
      ST_WR_TX1:  begin req = 1'b1; req_we = 1'b1; req_addr = SPI_BASE + REG_TX1;
                        req_wdata = {FLASH_READ_OP, cur_addr_q}; bus_next = ST_WR_TX0; end
      ST_WR_TX0:  begin req = 1'b1; req_we = 1'b1; req_addr = SPI_BASE + REG_TX0;
                        req_wdata = 32'h0; bus_next = ST_WR_CTRL; end
      ST_WR_CTRL: begin req = 1'b1; req_we = 1'b1; req_addr = SPI_BASE + REG_CTRL;
                        req_wdata = CTRL_GO; bus_next = ST_POLL; end
      ST_POLL:    begin req = 1'b1; req_addr = SPI_BASE + REG_CTRL;
                        bus_next = rsp_data[CTRL_GO_BSY_BIT] ? ST_POLL : ST_RD_RX; end
      ST_RD_RX:   begin req = 1'b1; req_addr = SPI_BASE + REG_RX0;
                        bus_next = ST_EMIT; end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          word_idx_d = 16'h0;
          count_d    = word_count_i;
          cur_addr_d = flash_base_i;
          if (word_count_i == 16'h0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WR_DIV;
          end
        end
      end
      ST_EMIT: begin
        word_idx_d = word_idx_q + 16'd1;
        cur_addr_d = cur_addr_q + 24'd4;
        if (word_idx_q + 16'd1 == count_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WR_TX1;
        end
      end
      ST_DONE, ST_ERR: ;
      default: begin
        if (rsp_valid) begin
          if (rsp_err) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = bus_next;
            // The write strobe is registered so it lines up with the EMIT cycle.
            if (state_q == ST_RD_RX) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = MEM_AW'(word_idx_q);
              mem_wdata_d = fmt_word(rsp_data);
            end
          end
        end
      end
    endcase

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= 16'h0;
      count_q     <= 16'h0;
      cur_addr_q  <= 24'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      cur_addr_q  <= cur_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: an SPI-host register model answers TL-UL traffic,
// and a scoreboard compares bus accesses and memory writes against a reference plan.
`timescale 1ns/1ps
module tb_spi_boot_loader;
  import tlul_pkg::*;

  localparam logic [31:0] BASE = 32'h4008_0000;
  localparam int          AW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   flash_base = '0;
  logic [15:0]   word_count = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, err;
  tl_h2d_t       tl_h;
  tl_d2h_t       tl_d;

  spi_boot_loader_if bus ();
  assign bus.h2d = tl_h;
  assign tl_d    = bus.d2h;

  spi_boot_loader #(
    .SPI_BASE (BASE),
    .CLK_DIV  (16'd1),
    .SS_MASK  (8'h01),
    .MEM_AW   (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .flash_base_i (flash_base),
    .word_count_i (word_count),
    .tl_o         (tl_h),
    .tl_i         (tl_d),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef SPI_BOOT_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } mw_t;

  bus_t        exp_bus[$];
  mw_t         exp_mem[$];
  logic [31:0] rx_q[$];
  int          poll_q[$];
  logic [31:0] pre_words[$];

  // Reference plan: what the loader must put on the bus and into memory.
  task automatic push_bus(input logic we, input logic [31:0] off, input logic [31:0] data);
    bus_t e;
    e.we = we; e.addr = BASE + off; e.data = data;
    exp_bus.push_back(e);
  endtask

  task automatic plan(input logic [23:0] base, input int count, input int fixed_poll);
    for (int i = 0; i < count; i++) begin
      logic [31:0] w;
      logic [23:0] fa;
      int          np;
      mw_t         m;
      w  = (pre_words.size() != 0) ? pre_words.pop_front() : $urandom;
      np = (fixed_poll >= 0) ? fixed_poll : int'($urandom_range(0, 2));
      fa = base + 24'(4 * i);
      rx_q.push_back(w);
      poll_q.push_back(np);
      if (i == 0) begin
        push_bus(1'b1, 32'h14, 32'h1);
        push_bus(1'b1, 32'h18, 32'h1);
      end
      push_bus(1'b1, 32'h04, {8'h03, fa});
      push_bus(1'b1, 32'h00, 32'h0);
      push_bus(1'b1, 32'h10, 32'h2540);
      for (int p = 0; p <= np; p++) push_bus(1'b0, 32'h10, 32'h0);
      push_bus(1'b0, 32'h00, 32'h0);
      m.addr = AW'(i % (1 << AW));
      m.data = exp_word(w);
      exp_mem.push_back(m);
    end
  endtask

  // SPI host register model
  bit          pend = 0;
  int          pend_dly = 0;
  logic [31:0] pend_data = '0;
  bit          pend_err = 0;
  bit          pend_rd = 0;
  int          busy_left = -1;
  int          stall_tx1 = 0;
  bit          err_next_poll = 0;
  bit          snap_v = 0;
  tl_h2d_t     snap;

  initial begin
    bus.d2h = '0;
    forever begin
      @(posedge clk); #1;
      bus.d2h.d_valid = 1'b0;
      bus.d2h.d_error = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          bus.d2h.d_valid  = 1'b1;
          bus.d2h.d_data   = pend_data;
          bus.d2h.d_error  = pend_err;
          bus.d2h.d_opcode = pend_rd ? AccessAckData : AccessAck;
          bus.d2h.d_size   = 2'd2;
          pend = 0;
        end else begin
          pend_dly--;
        end
      end
      bus.d2h.a_ready = 1'b0;
      if (tl_h.a_valid && !pend) begin
        if (tl_h.a_opcode == PutFullData && tl_h.a_address == BASE + 32'h04 && stall_tx1 > 0) begin
          if (!snap_v) begin
            snap   = tl_h;
            snap_v = 1;
          end else begin
            check("stall_addr", {tl_h.a_opcode, tl_h.a_address}, {snap.a_opcode, snap.a_address});
            check("stall_data", tl_h.a_data, snap.a_data);
          end
          stall_tx1--;
        end else begin
          bus.d2h.a_ready = ($urandom_range(0, 3) != 0);
        end
      end else if (snap_v && stall_tx1 > 0) begin
        check("stall_valid", tl_h.a_valid, 1'b1);
      end
      if (tl_h.a_valid && bus.d2h.a_ready) begin
        pend      = 1;
        pend_dly  = int'($urandom_range(0, 2));
        pend_err  = 0;
        pend_data = 32'h0;
        pend_rd   = (tl_h.a_opcode == Get);
        if (pend_rd && tl_h.a_address == BASE + 32'h10) begin
          if (err_next_poll) begin
            pend_err      = 1;
            err_next_poll = 0;
          end else begin
            if (busy_left < 0) busy_left = (poll_q.size() != 0) ? poll_q.pop_front() : 0;
            if (busy_left > 0) begin
              pend_data = 32'h2540;
              busy_left--;
            end else begin
              pend_data = 32'h2440;
              busy_left = -1;
            end
          end
        end else if (pend_rd && tl_h.a_address == BASE) begin
          pend_data = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Scoreboard monitor
  bit poll_seen = 0;

  initial forever begin
    @(negedge clk);
    if (!rst && tl_h.a_valid && tl_d.a_ready) begin
      if (tl_h.a_opcode == Get && tl_h.a_address == BASE + 32'h10) poll_seen = 1;
      if (exp_bus.size() == 0) begin
        check("bus_extra", {29'h0, tl_h.a_opcode, tl_h.a_address}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        check("bus_cmd",
              {tl_h.a_opcode, tl_h.a_mask, tl_h.a_size, tl_h.a_source, tl_h.a_address},
              {(e.we ? 3'd0 : 3'd4), 4'hF, 2'd2, 8'd0, e.addr});
        if (e.we) check("bus_wdata", tl_h.a_data, e.data);
      end
    end
    if (!rst && mem_we) begin
      if (exp_mem.size() == 0) begin
        check("mem_extra", {29'h0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mw_t m;
        m = exp_mem.pop_front();
        check("mem_write", {mem_addr, mem_wdata}, {m.addr, m.data});
        check("busy_emit", busy, 1'b1);
      end
    end
  end

  task automatic flush_model();
    exp_bus.delete();
    exp_mem.delete();
    rx_q.delete();
    poll_q.delete();
    pre_words.delete();
    busy_left     = -1;
    stall_tx1     = 0;
    err_next_poll = 0;
    snap_v        = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    flush_model();
  endtask

  task automatic run_boot(input logic [23:0] base, input int count, input bit exp_err);
    int cyc;
    flash_base = base;
    word_count = 16'(count);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || err) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("finish_in_time", (cyc < 4000), 1'b1);
    repeat (4) @(negedge clk);
    check("end_flags", {done, err, busy}, {!exp_err, exp_err, 1'b0});
    check("bus_left", exp_bus.size(), 0);
    check("mem_left", exp_mem.size(), 0);
  endtask

  initial begin
    int quiet;
    repeat (3) @(negedge clk);
    check("reset_outs", {tl_h.a_valid, tl_h.d_ready, mem_we, mem_addr, mem_wdata, busy, done, err},
          {1'b0, 1'b1, 1'b0, {AW{1'b0}}, 32'h0, 3'b000});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outs", {tl_h.a_valid, tl_h.d_ready, busy, done, err}, 5'b01000);

    // Two fixed words from 0x000100
    pre_words.push_back(32'hDEAD_BEEF);
    pre_words.push_back(32'h0123_4567);
    plan(24'h000100, 2, -1);
    run_boot(24'h000100, 2, 1'b0);
    do_reset();

    // Busy bit held for three polls
    plan(24'h0ABC00, 1, 3);
    run_boot(24'h0ABC00, 1, 1'b0);
    do_reset();

    // a_ready withheld on the first TX1 write
    stall_tx1 = 5;
    plan(24'h123450, 2, -1);
    run_boot(24'h123450, 2, 1'b0);
    check("stall_seen", {snap_v, 31'(stall_tx1)}, {1'b1, 31'd0});
    do_reset();

    // Error response on the first poll
    err_next_poll = 1;
    push_bus(1'b1, 32'h14, 32'h1);
    push_bus(1'b1, 32'h18, 32'h1);
    push_bus(1'b1, 32'h04, 32'h0300_0040);
    push_bus(1'b1, 32'h00, 32'h0);
    push_bus(1'b1, 32'h10, 32'h2540);
    push_bus(1'b0, 32'h10, 32'h0);
    run_boot(24'h000040, 3, 1'b1);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      quiet += int'(tl_h.a_valid) + int'(mem_we);
    end
    check("quiet_after_err", quiet, 0);
    do_reset();

    // Zero-length image
    flash_base = 24'h001000;
    word_count = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("count0_done", {done, busy, err}, 3'b100);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      quiet += int'(tl_h.a_valid);
    end
    check("count0_no_bus", quiet, 0);
    do_reset();

    // Flash address wraps past 0xFFFFFF
    plan(24'hFFFFFC, 2, -1);
    run_boot(24'hFFFFFC, 2, 1'b0);
    do_reset();

    // Memory address wraps past 2^AW words
    plan(24'h200000, 10, 0);
    run_boot(24'h200000, 10, 1'b0);
    do_reset();

    // Reset while polling, then replay
    begin
      int cyc;
      plan(24'h005500, 2, 6);
      poll_seen = 0;
      flash_base = 24'h005500;
      word_count = 16'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!poll_seen && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      check("poll_reached", poll_seen, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("reset_midpoll", {tl_h.a_valid, tl_h.d_ready, mem_we, busy, done, err}, 6'b010000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_after_rst", {tl_h.a_valid, busy, done, err}, 4'b0000);
      flush_model();
      plan(24'h005500, 2, -1);
      run_boot(24'h005500, 2, 1'b0);
      do_reset();
    end

    // Random images
    for (int t = 0; t < 4; t++) begin
      logic [23:0] b;
      int          c;
      b = 24'($urandom) & 24'hFFFFFC;
      c = int'($urandom_range(1, 5));
      plan(b, c, -1);
      run_boot(b, c, 1'b0);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
